// File: rtl/sweep_ctrl_if.sv
// Configuration handshake between the register/control wrapper (master)
// and the sweep run-control sequencer (slave).
interface sweep_ctrl_if #(
    parameter int PRESC_W = 14,
    parameter int REP_W   = 8
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [PRESC_W-1:0] cfg_prescaler;
    logic [REP_W-1:0]   cfg_repeat;
    logic               cfg_continuous;

    modport master (
        output cfg_valid,
        output cfg_prescaler,
        output cfg_repeat,
        output cfg_continuous,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_prescaler,
        input  cfg_repeat,
        input  cfg_continuous,
        output cfg_ready
    );
endinterface

// File: rtl/sweep_ctrl.sv
// Run-control sequencer for the GPIO sweep core: takes a configuration,
// starts/pauses/aborts runs and counts completed sweeps from core_done.
module sweep_ctrl #(
    parameter int PRESC_W = 14,
    parameter int REP_W   = 8
) (
    input  logic               clk,
    input  logic               nrst,
    sweep_ctrl_if.slave        cfg,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    input  logic               irq_clr,
    output logic               busy,
    output logic               paused,
    output logic               cfg_err,
    output logic [REP_W-1:0]   sweep_count,
    output logic               sweep_tick,
    output logic               irq_done,
    output logic               core_enable,
    output logic               core_stop,
    output logic [PRESC_W-1:0] core_prescaler,
    input  logic               core_done
);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, PAUSE, FINISH} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PRESC_W-1:0] shadow_presc;
    logic [REP_W-1:0]   shadow_rep;
    logic               shadow_cont;
    logic [PRESC_W-1:0] run_presc;
    logic [REP_W-1:0]   run_rep;
    logic               run_cont;
    logic               done_q;

    logic               cfg_fire;
    logic               start_ok;
    logic               start_bad;
    logic               sweep_edge;
    logic               count_en;
    logic               last_edge;
    logic [REP_W-1:0]   count_inc;
    logic [REP_W-1:0]   eff_rep;

    assign cfg_fire   = cfg.cfg_valid & cfg.cfg_ready;
    assign start_ok   = (state == IDLE) & start & (shadow_presc != '0);
    assign start_bad  = (state == IDLE) & start & (shadow_presc == '0);
    assign sweep_edge = core_done & ~done_q;
    assign count_inc  = sweep_count + REP_W'(1);
    assign eff_rep    = (run_rep == '0) ? REP_W'(1) : run_rep;
    assign last_edge  = sweep_edge & ~run_cont & (count_inc == eff_rep);
    assign count_en   = (state == RUN) & sweep_edge & ~abort;

    assign sweep_tick     = count_en;
    assign core_prescaler = run_presc;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok) state_nxt = CLEAR;
            CLEAR:   state_nxt = abort ? IDLE : RUN;
            RUN: begin
                if (abort)          state_nxt = IDLE;
                else if (last_edge) state_nxt = FINISH;
                else if (pause)     state_nxt = PAUSE;
            end
            PAUSE: begin
                if (abort)       state_nxt = IDLE;
                else if (!pause) state_nxt = RUN;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        core_enable   = 1'b0;
        core_stop     = 1'b1;
        busy          = (state != IDLE);
        paused        = (state == PAUSE);
        cfg.cfg_ready = (state == IDLE);
        unique case (state)
            RUN:     begin core_enable = 1'b1; core_stop = 1'b0; end
            PAUSE:   core_stop = 1'b0;
            default: ;
        endcase
    end

    // The run copies freeze the configuration at start, so a handshake that
    // coincides with start only affects the following run.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shadow_presc <= '0;
            shadow_rep   <= REP_W'(1);
            shadow_cont  <= 1'b0;
            run_presc    <= '0;
            run_rep      <= REP_W'(1);
            run_cont     <= 1'b0;
            done_q       <= 1'b0;
            sweep_count  <= '0;
            cfg_err      <= 1'b0;
            irq_done     <= 1'b0;
        end else begin
            if (cfg_fire) begin
                shadow_presc <= cfg.cfg_prescaler;
                shadow_rep   <= cfg.cfg_repeat;
                shadow_cont  <= cfg.cfg_continuous;
            end
            if (start_ok) begin
                run_presc <= shadow_presc;
                run_rep   <= shadow_rep;
                run_cont  <= shadow_cont;
            end else if (cfg_fire) begin
                run_presc <= cfg.cfg_prescaler;
                run_rep   <= cfg.cfg_repeat;
                run_cont  <= cfg.cfg_continuous;
            end
            done_q <= start_ok ? 1'b0 : core_done;
            if (start_ok)      sweep_count <= '0;
            else if (count_en) sweep_count <= count_inc;
            if (start_bad)     cfg_err <= 1'b1;
            else if (cfg_fire) cfg_err <= 1'b0;
            if (state == FINISH) irq_done <= 1'b1;
            else if (irq_clr)    irq_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed self-checking bench for sweep_ctrl; core_done is driven directly
// so sweeps are compressed to a few clock cycles.
module tb_sweep_ctrl;
    localparam int PRESC_W = 14;
    localparam int REP_W   = 8;

    logic               clk = 1'b0;
    logic               nrst = 1'b0;
    logic               start = 1'b0;
    logic               pause = 1'b0;
    logic               abort = 1'b0;
    logic               irq_clr = 1'b0;
    logic               core_done = 1'b0;
    logic               busy, paused, cfg_err, sweep_tick, irq_done;
    logic               core_enable, core_stop;
    logic [REP_W-1:0]   sweep_count;
    logic [PRESC_W-1:0] core_prescaler;

    int checks = 0;
    int errors = 0;

    sweep_ctrl_if #(.PRESC_W(PRESC_W), .REP_W(REP_W)) cfg_bus ();

    sweep_ctrl #(.PRESC_W(PRESC_W), .REP_W(REP_W)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .cfg            (cfg_bus.slave),
        .start          (start),
        .pause          (pause),
        .abort          (abort),
        .irq_clr        (irq_clr),
        .busy           (busy),
        .paused         (paused),
        .cfg_err        (cfg_err),
        .sweep_count    (sweep_count),
        .sweep_tick     (sweep_tick),
        .irq_done       (irq_done),
        .core_enable    (core_enable),
        .core_stop      (core_stop),
        .core_prescaler (core_prescaler),
        .core_done      (core_done)
    );

    always #50 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input int p, input int r, input bit c);
        cfg_bus.cfg_valid      = 1'b1;
        cfg_bus.cfg_prescaler  = PRESC_W'(p);
        cfg_bus.cfg_repeat     = REP_W'(r);
        cfg_bus.cfg_continuous = c;
        step();
        cfg_bus.cfg_valid = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic clear_irq();
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        #1;
        checks++; if (core_stop !== 1'b1) begin errors++; $display("[TB] FAIL reset_stop got %0b want 1", core_stop); end
        checks++; if (core_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_enable got %0b want 0", core_enable); end
        checks++; if (cfg_bus.cfg_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %0b want 1", cfg_bus.cfg_ready); end
        checks++; if (irq_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq got %0b want 0", irq_done); end
        checks++; if (sweep_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", sweep_count); end
        checks++; if (busy !== 1'b0 || core_prescaler !== 14'd0) begin errors++; $display("[TB] FAIL reset_busy_presc got %0b/%0d want 0/0", busy, core_prescaler); end
        @(negedge clk);
        nrst = 1'b1;
        step();
    endtask

    task automatic test_finite_run();
        load_cfg(1, 3, 1'b0);
        checks++; if (core_prescaler !== 14'd1) begin errors++; $display("[TB] FAIL fin_presc got %0d want 1", core_prescaler); end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (core_enable !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL fin_clear got en=%0b busy=%0b want 0/1", core_enable, busy); end
        step();
        checks++; if (core_enable !== 1'b1 || core_stop !== 1'b0) begin errors++; $display("[TB] FAIL fin_run got en=%0b stop=%0b want 1/0", core_enable, core_stop); end
        for (int i = 0; i < 3; i++) begin
            repeat (4) step();
            core_done = 1'b1;
            #1;
            checks++; if (sweep_tick !== 1'b1) begin errors++; $display("[TB] FAIL fin_tick%0d got %0b want 1", i, sweep_tick); end
            step();
            checks++; if (sweep_count !== 8'(i + 1)) begin errors++; $display("[TB] FAIL fin_count%0d got %0d want %0d", i, sweep_count, i + 1); end
            #1;
            checks++; if (sweep_tick !== 1'b0) begin errors++; $display("[TB] FAIL fin_tick_hold%0d got %0b want 0", i, sweep_tick); end
            core_done = 1'b0;
        end
        checks++; if (core_stop !== 1'b1 || core_enable !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL fin_finish got stop=%0b en=%0b busy=%0b want 1/0/1", core_stop, core_enable, busy); end
        step();
        checks++; if (irq_done !== 1'b1 || busy !== 1'b0 || sweep_count !== 8'd3) begin errors++; $display("[TB] FAIL fin_done got irq=%0b busy=%0b cnt=%0d want 1/0/3", irq_done, busy, sweep_count); end
        clear_irq();
        checks++; if (irq_done !== 1'b0) begin errors++; $display("[TB] FAIL fin_irq_clr got %0b want 0", irq_done); end
    endtask

    task automatic test_cfg_err();
        load_cfg(0, 1, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b0 || cfg_err !== 1'b1 || core_enable !== 1'b0) begin errors++; $display("[TB] FAIL err_set got busy=%0b err=%0b en=%0b want 0/1/0", busy, cfg_err, core_enable); end
        step();
        checks++; if (busy !== 1'b0 || cfg_err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky got busy=%0b err=%0b want 0/1", busy, cfg_err); end
        load_cfg(2, 1, 1'b0);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("[TB] FAIL err_clear got %0b want 0", cfg_err); end
    endtask

    task automatic test_pause();
        int bad;
        bad = 0;
        load_cfg(2, 2, 1'b0);
        start_run();
        repeat (3) step();
        core_done = 1'b1;
        pause = 1'b1;
        step();
        core_done = 1'b0;
        checks++; if (sweep_count !== 8'd1 || paused !== 1'b1) begin errors++; $display("[TB] FAIL pause_edge got cnt=%0d paused=%0b want 1/1", sweep_count, paused); end
        for (int i = 0; i < 50; i++) begin
            if (paused !== 1'b1 || core_enable !== 1'b0 || core_stop !== 1'b0) bad++;
            step();
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL pause_hold got %0d bad cycles want 0", bad); end
        pause = 1'b0;
        step();
        checks++; if (core_enable !== 1'b1 || paused !== 1'b0) begin errors++; $display("[TB] FAIL pause_resume got en=%0b paused=%0b want 1/0", core_enable, paused); end
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        step();
        checks++; if (sweep_count !== 8'd2 || irq_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL pause_end got cnt=%0d irq=%0b busy=%0b want 2/1/0", sweep_count, irq_done, busy); end
        clear_irq();
    endtask

    task automatic test_continuous_wrap();
        load_cfg(1, 0, 1'b1);
        start_run();
        for (int i = 0; i < 256; i++) begin
            core_done = 1'b1;
            step();
            core_done = 1'b0;
            step();
        end
        checks++; if (sweep_count !== 8'd0 || core_enable !== 1'b1) begin errors++; $display("[TB] FAIL cont_256 got cnt=%0d en=%0b want 0/1", sweep_count, core_enable); end
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        step();
        checks++; if (sweep_count !== 8'd1 || irq_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL cont_257 got cnt=%0d irq=%0b busy=%0b want 1/0/1", sweep_count, irq_done, busy); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (core_stop !== 1'b1 || busy !== 1'b0 || sweep_count !== 8'd1 || irq_done !== 1'b0) begin errors++; $display("[TB] FAIL cont_abort got stop=%0b busy=%0b cnt=%0d irq=%0b want 1/0/1/0", core_stop, busy, sweep_count, irq_done); end
    endtask

    task automatic test_same_cycle();
        load_cfg(1, 3, 1'b0);
        start_run();
        step();
        core_done = 1'b1;
        abort = 1'b1;
        #1;
        checks++; if (sweep_tick !== 1'b0) begin errors++; $display("[TB] FAIL abort_tick got %0b want 0", sweep_tick); end
        step();
        core_done = 1'b0;
        abort = 1'b0;
        checks++; if (sweep_count !== 8'd0 || busy !== 1'b0 || irq_done !== 1'b0) begin errors++; $display("[TB] FAIL abort_edge got cnt=%0d busy=%0b irq=%0b want 0/0/0", sweep_count, busy, irq_done); end
        load_cfg(1, 1, 1'b0);
        start_run();
        core_done = 1'b1;
        pause = 1'b1;
        step();
        core_done = 1'b0;
        checks++; if (paused !== 1'b0 || core_stop !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL final_pause got paused=%0b stop=%0b busy=%0b want 0/1/1", paused, core_stop, busy); end
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        pause = 1'b0;
        checks++; if (irq_done !== 1'b1 || busy !== 1'b0 || sweep_count !== 8'd1) begin errors++; $display("[TB] FAIL final_irq got irq=%0b busy=%0b cnt=%0d want 1/0/1", irq_done, busy, sweep_count); end
        clear_irq();
    endtask

    task automatic test_cfg_stall();
        load_cfg(1, 2, 1'b0);
        start_run();
        cfg_bus.cfg_valid      = 1'b1;
        cfg_bus.cfg_prescaler  = 14'd5;
        cfg_bus.cfg_repeat     = 8'd1;
        cfg_bus.cfg_continuous = 1'b0;
        step();
        checks++; if (cfg_bus.cfg_ready !== 1'b0 || core_prescaler !== 14'd1) begin errors++; $display("[TB] FAIL stall_ready got rdy=%0b presc=%0d want 0/1", cfg_bus.cfg_ready, core_prescaler); end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (core_enable !== 1'b1 || sweep_count !== 8'd0) begin errors++; $display("[TB] FAIL busy_start got en=%0b cnt=%0d want 1/0", core_enable, sweep_count); end
        for (int i = 0; i < 2; i++) begin
            core_done = 1'b1;
            step();
            core_done = 1'b0;
            step();
        end
        checks++; if (busy !== 1'b0 || cfg_bus.cfg_ready !== 1'b1 || core_prescaler !== 14'd1 || sweep_count !== 8'd2) begin errors++; $display("[TB] FAIL stall_idle got busy=%0b rdy=%0b presc=%0d cnt=%0d want 0/1/1/2", busy, cfg_bus.cfg_ready, core_prescaler, sweep_count); end
        step();
        cfg_bus.cfg_valid = 1'b0;
        checks++; if (core_prescaler !== 14'd5) begin errors++; $display("[TB] FAIL stall_load got %0d want 5", core_prescaler); end
        clear_irq();
        start_run();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        checks++; if (core_stop !== 1'b1 || busy !== 1'b1 || sweep_count !== 8'd1) begin errors++; $display("[TB] FAIL stall_rep1 got stop=%0b busy=%0b cnt=%0d want 1/1/1", core_stop, busy, sweep_count); end
        step();
    endtask

    task automatic test_midrun_reset();
        start_run();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        @(negedge clk);
        nrst = 1'b0;
        #1;
        checks++; if (core_stop !== 1'b1 || busy !== 1'b0 || sweep_count !== 8'd0 || irq_done !== 1'b0 || core_prescaler !== 14'd0) begin errors++; $display("[TB] FAIL midrun_reset got stop=%0b busy=%0b cnt=%0d irq=%0b presc=%0d want 1/0/0/0/0", core_stop, busy, sweep_count, irq_done, core_prescaler); end
        @(negedge clk);
        nrst = 1'b1;
        step();
    endtask

    initial begin
        cfg_bus.cfg_valid      = 1'b0;
        cfg_bus.cfg_prescaler  = '0;
        cfg_bus.cfg_repeat     = '0;
        cfg_bus.cfg_continuous = 1'b0;
        test_reset();
        test_finite_run();
        test_cfg_err();
        test_pause();
        test_continuous_wrap();
        test_same_cycle();
        test_cfg_stall();
        test_midrun_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL timeout got no finish want finish");
        $fatal(1, "[TB] timeout");
    end
endmodule
